// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and baud divider computation
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic int calc_div(input int clk_rate, input int baud_rate, input int num_ticks);
    int d;
    d = clk_rate / (baud_rate * num_ticks);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: free-running divider emitting a 1-cycle oversampling tick
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int NUM_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  output logic s_tick
);
  localparam int DIV = calc_div(CLK_RATE, BAUD_RATE, NUM_TICKS);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign s_tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk) cnt <= rst || s_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_unit.sv
// uart_unit: full-duplex 8N1 UART with shared oversampling baud generator
module uart_unit
  import uart_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int NUM_TICKS = 16,
  parameter int BAUD_RATE = 9600,
  parameter int CLK_RATE  = 100000000
) (
  input  logic             CLK_100MHZ,
  input  logic             reset,
  input  logic             tx_start,
  input  logic             rx,
  input  logic [NBITS-1:0] data_in,
  output logic [NBITS-1:0] data_out,
  output logic             rx_done_tick,
  output logic             tx,
  output logic             tx_done_tick
);
  localparam int SW = $clog2(NUM_TICKS);
  localparam int NW = $clog2(NBITS + 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] S_HALF = SW'(NUM_TICKS / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NBITS - 1);
  logic s_tick;
  baud_rate_gen #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .NUM_TICKS(NUM_TICKS)) u_baud (
    .clk(CLK_100MHZ),
    .rst(reset),
    .s_tick(s_tick)
  );
  state_t rx_state, rx_state_nx;
  logic [SW-1:0] rx_s, rx_s_nx;
  logic [NW-1:0] rx_n, rx_n_nx;
  logic [NBITS-1:0] rx_b, rx_b_nx, data_nx;
  logic rx_done_nx;
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      rx_state     <= IDLE;
      rx_s         <= '0;
      rx_n         <= '0;
      rx_b         <= '0;
      data_out     <= '0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_state     <= rx_state_nx;
      rx_s         <= rx_s_nx;
      rx_n         <= rx_n_nx;
      rx_b         <= rx_b_nx;
      data_out     <= data_nx;
      rx_done_tick <= rx_done_nx;
    end
  end
  always_comb begin
    rx_state_nx = rx_state;
    rx_s_nx     = rx_s;
    rx_n_nx     = rx_n;
    rx_b_nx     = rx_b;
    data_nx     = data_out;
    rx_done_nx  = 1'b0;
    case (rx_state)
      IDLE: if (!rx) begin
        rx_state_nx = START;
        rx_s_nx     = '0;
      end
      START: if (s_tick) begin
        if (rx_s == S_HALF) begin
          rx_state_nx = rx ? IDLE : DATA;
          rx_s_nx     = '0;
          rx_n_nx     = '0;
        end else rx_s_nx = rx_s + 1'b1;
      end
      DATA: if (s_tick) begin
        if (rx_s == S_LAST) begin
          rx_s_nx     = '0;
          rx_b_nx     = {rx, rx_b[NBITS-1:1]};
          rx_n_nx     = rx_n + 1'b1;
          rx_state_nx = rx_n == N_LAST ? STOP : DATA;
        end else rx_s_nx = rx_s + 1'b1;
      end
      STOP: if (s_tick) begin
        if (rx_s == S_LAST) begin
          rx_state_nx = IDLE;
          rx_done_nx  = 1'b1;
          data_nx     = rx_b;
        end else rx_s_nx = rx_s + 1'b1;
      end
      default: rx_state_nx = IDLE;
    endcase
  end
  state_t tx_state, tx_state_nx;
  logic [SW-1:0] tx_s, tx_s_nx;
  logic [NW-1:0] tx_n, tx_n_nx;
  logic [NBITS-1:0] tx_b, tx_b_nx;
  logic tx_nx, tx_done_nx;
  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      tx_state     <= IDLE;
      tx_s         <= '0;
      tx_n         <= '0;
      tx_b         <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      tx_state     <= tx_state_nx;
      tx_s         <= tx_s_nx;
      tx_n         <= tx_n_nx;
      tx_b         <= tx_b_nx;
      tx           <= tx_nx;
      tx_done_tick <= tx_done_nx;
    end
  end
  always_comb begin
    tx_state_nx = tx_state;
    tx_s_nx     = tx_s;
    tx_n_nx     = tx_n;
    tx_b_nx     = tx_b;
    tx_nx       = 1'b1;
    tx_done_nx  = 1'b0;
    case (tx_state)
      IDLE: if (tx_start) begin
        tx_state_nx = START;
        tx_s_nx     = '0;
        tx_b_nx     = data_in;
      end
      START: begin
        tx_nx = 1'b0;
        if (s_tick) begin
          if (tx_s == S_LAST) begin
            tx_state_nx = DATA;
            tx_s_nx     = '0;
            tx_n_nx     = '0;
          end else tx_s_nx = tx_s + 1'b1;
        end
      end
      DATA: begin
        tx_nx = tx_b[0];
        if (s_tick) begin
          if (tx_s == S_LAST) begin
            tx_s_nx     = '0;
            tx_b_nx     = tx_b >> 1;
            tx_n_nx     = tx_n + 1'b1;
            tx_state_nx = tx_n == N_LAST ? STOP : DATA;
          end else tx_s_nx = tx_s + 1'b1;
        end
      end
      STOP: if (s_tick) begin
        if (tx_s == S_LAST) begin
          tx_state_nx = IDLE;
          tx_done_nx  = 1'b1;
        end else tx_s_nx = tx_s + 1'b1;
      end
      default: tx_state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_unit.sv
// tb_uart_unit: directed table-driven loopback bench for uart_unit
module tb_uart_unit;
  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_start = 1'b0;
  logic rx_drv = 1'b1;
  logic loop = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic rx;
  logic [7:0] data_out;
  logic rx_done_tick, tx, tx_done_tick;
  int checks = 0, failures = 0, cyc = 0, rx_cnt = 0, tx_cnt = 0, wide = 0;
  logic rx_prev = 1'b0, tx_prev = 1'b0;
  vec_t vecs[6];
  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;
  uart_unit #(.NBITS(8), .NUM_TICKS(16), .BAUD_RATE(625000), .CLK_RATE(100000000)) u_dut (
    .CLK_100MHZ(clk),
    .reset(reset),
    .tx_start(tx_start),
    .rx(rx),
    .data_in(data_in),
    .data_out(data_out),
    .rx_done_tick(rx_done_tick),
    .tx(tx),
    .tx_done_tick(tx_done_tick)
  );
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rx_done_tick) rx_cnt++;
    if (tx_done_tick) tx_cnt++;
    if ((rx_done_tick && rx_prev) || (tx_done_tick && tx_prev)) wide++;
    rx_prev = rx_done_tick;
    tx_prev = tx_done_tick;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic wait_tx_low();
    int k = 0;
    while (tx !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("tx_start_bit_seen", k < 300, 1);
  endtask
  task automatic send_check(input logic [7:0] d, input logic [9:0] frame);
    int t0, rxc, txc, k;
    logic [9:0] got;
    rxc = rx_cnt;
    txc = tx_cnt;
    @(negedge clk);
    data_in = d;
    tx_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    tx_start = 1'b0;
    data_in = ~d;
    wait_tx_low();
    for (int i = 0; i < 10; i++) begin
      repeat (i == 0 ? 80 : 160) @(negedge clk);
      got[i] = tx;
    end
    chk("tx_frame_bits", got, frame);
    k = 0;
    while (tx_cnt == txc && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk_rng("tx_frame_len", cyc - t0, 1585, 1610);
    chk("tx_done_count", tx_cnt - txc, 1);
    chk("rx_done_count", rx_cnt - rxc, 1);
    chk("data_out", data_out, d);
  endtask
  initial begin
    int t1, k, rxc, txc, lows;
    vecs[0] = '{8'h03, 10'b1_00000011_0};
    vecs[1] = '{8'h06, 10'b1_00000110_0};
    vecs[2] = '{8'hA5, 10'b1_10100101_0};
    vecs[3] = '{8'h00, 10'b1_00000000_0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0};
    vecs[5] = '{8'h80, 10'b1_10000000_0};
    repeat (2) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_data_out", data_out, 0);
    chk("reset_rx_done", rx_done_tick, 0);
    chk("reset_tx_done", tx_done_tick, 0);
    reset = 1'b0;
    k = 0;
    while (!u_dut.u_baud.s_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    t1 = cyc;
    @(negedge clk);
    k = 0;
    while (!u_dut.u_baud.s_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("s_tick_period", cyc - t1, 10);
    for (int i = 0; i < 6; i++) send_check(vecs[i].d, vecs[i].frame);
    rxc = rx_cnt;
    txc = tx_cnt;
    @(negedge clk);
    data_in = 8'h03;
    tx_start = 1'b1;
    repeat (1000) @(negedge clk);
    tx_start = 1'b0;
    repeat (2500) @(negedge clk);
    chk("held_10us_tx_frames", tx_cnt - txc, 1);
    chk("held_10us_rx_frames", rx_cnt - rxc, 1);
    rxc = rx_cnt;
    txc = tx_cnt;
    tx_start = 1'b1;
    repeat (4000) @(negedge clk);
    tx_start = 1'b0;
    repeat (3000) @(negedge clk);
    chk("held_40us_tx_frames", tx_cnt - txc, 3);
    chk("held_40us_rx_frames", rx_cnt - rxc, 3);
    chk("held_40us_data_out", data_out, 8'h03);
    rxc = rx_cnt;
    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (50) @(negedge clk);
    rx_drv = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_no_rx_done", rx_cnt - rxc, 0);
    chk("glitch_data_out_held", data_out, 8'h03);
    loop = 1'b1;
    rxc = rx_cnt;
    txc = tx_cnt;
    data_in = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_tx_low();
    repeat (80 + 4 * 160) @(negedge clk);
    chk("pre_reset_bit3", tx, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_frame_tx", tx, 1);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("after_abort_tx_idle", lows, 0);
    chk("abort_no_tx_done", tx_cnt - txc, 0);
    chk("abort_no_rx_done", rx_cnt - rxc, 0);
    send_check(8'hC3, 10'b1_11000011_0);
    chk("done_pulse_width", wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
